// File: rtl/rope_step_scheduler_if.sv
// Bundles the mouse/display front-end and rope-core array signals around the step scheduler.
// The scheduler takes the master side; the environment (cores, display, mouse) takes the slave side.
interface rope_step_scheduler_if #(
  parameter int CORE_CONTAINS  = 4,
  parameter int NODES_PER_CORE = 5
);
  localparam int NW = CORE_CONTAINS * NODES_PER_CORE * 10;

  logic [9:0]               in_mouse_x;
  logic [9:0]               in_mouse_y;
  logic                     mouse_valid;
  logic                     vblank;
  logic [CORE_CONTAINS-1:0] core_done;
  logic [NW-1:0]            nodes_x_in;
  logic [NW-1:0]            nodes_y_in;
  logic                     core_step;
  logic [9:0]               mouse_x;
  logic [9:0]               mouse_y;
  logic [NW-1:0]            nodes_x_out;
  logic [NW-1:0]            nodes_y_out;
  logic                     frame_valid;
  logic [15:0]              step_count;
  logic                     busy;
  logic                     timeout_err;
  logic                     overrun_err;

  modport master (
    input  in_mouse_x, in_mouse_y, mouse_valid, vblank, core_done, nodes_x_in, nodes_y_in,
    output core_step, mouse_x, mouse_y, nodes_x_out, nodes_y_out, frame_valid, step_count,
           busy, timeout_err, overrun_err
  );

  modport slave (
    output in_mouse_x, in_mouse_y, mouse_valid, vblank, core_done, nodes_x_in, nodes_y_in,
    input  core_step, mouse_x, mouse_y, nodes_x_out, nodes_y_out, frame_valid, step_count,
           busy, timeout_err, overrun_err
  );
endinterface

// File: rtl/rope_step_scheduler.sv
// Per-tick sequencer for the rope engine: latches the mouse, runs ITERATIONS step/ack passes
// with a watchdog, then publishes the node snapshot to the display during vblank.
module rope_step_scheduler #(
  parameter int CORE_CONTAINS  = 4,
  parameter int NODES_PER_CORE = 5,
  parameter int TICK_DIV       = 416667,
  parameter int ITERATIONS     = 8,
  parameter int TIMEOUT        = 1024
) (
  input logic                   clk,
  input logic                   reset,
  rope_step_scheduler_if.master bus
);
  localparam int NW = CORE_CONTAINS * NODES_PER_CORE * 10;
  localparam int TW = $clog2(TICK_DIV);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int IW = $clog2(ITERATIONS + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH    = 3'd1,
    STEP     = 3'd2,
    WAIT     = 3'd3,
    PUB_WAIT = 3'd4,
    PUBLISH  = 3'd5
  } state_t;

  state_t                   state_r, state_s;
  logic [TW-1:0]            tick_cnt_r;
  logic                     tick_pending_r;
  logic [IW-1:0]            iter_r;
  logic [CORE_CONTAINS-1:0] done_seen_r;
  logic [WW-1:0]            watchdog_r;
  logic                     core_step_r;
  logic [9:0]               mouse_x_r;
  logic [9:0]               mouse_y_r;
  logic [NW-1:0]            nodes_x_r;
  logic [NW-1:0]            nodes_y_r;
  logic                     frame_valid_r;
  logic [15:0]              step_count_r;
  logic                     busy_r;
  logic                     timeout_err_r;
  logic                     overrun_err_r;

  logic tick_wrap_s, done_all_s, wd_expire_s, wait_done_s, last_iter_s;

  assign tick_wrap_s = (tick_cnt_r == TW'(TICK_DIV - 1));
  assign done_all_s  = &(done_seen_r | bus.core_done);
  assign wd_expire_s = (watchdog_r == WW'(TIMEOUT - 1));
  assign wait_done_s = done_all_s | wd_expire_s;
  assign last_iter_s = (iter_r == IW'(ITERATIONS - 1));

  // Free-running tick divider; a wrap coinciding with LATCH refills the slot just consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_r     <= '0;
      tick_pending_r <= 1'b0;
      overrun_err_r  <= 1'b0;
    end else begin
      if (tick_wrap_s) begin
        tick_cnt_r     <= '0;
        tick_pending_r <= 1'b1;
        if (tick_pending_r && (state_r != LATCH)) begin
          overrun_err_r <= 1'b1;
        end
      end else begin
        tick_cnt_r <= tick_cnt_r + TW'(1);
        if (state_r == LATCH) begin
          tick_pending_r <= 1'b0;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (tick_pending_r) state_s = LATCH;
        else                state_s = IDLE;
      end
      LATCH: state_s = STEP;
      STEP:  state_s = WAIT;
      WAIT: begin
        if (wait_done_s) begin
          if (last_iter_s) state_s = PUB_WAIT;
          else             state_s = STEP;
        end else begin
          state_s = WAIT;
        end
      end
      PUB_WAIT: begin
        if (bus.vblank) state_s = PUBLISH;
        else            state_s = PUB_WAIT;
      end
      PUBLISH: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Per-state datapath updates; strobes are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iter_r        <= '0;
      done_seen_r   <= '0;
      watchdog_r    <= '0;
      mouse_x_r     <= 10'd0;
      mouse_y_r     <= 10'd0;
      nodes_x_r     <= '0;
      nodes_y_r     <= '0;
      step_count_r  <= 16'd0;
      timeout_err_r <= 1'b0;
      core_step_r   <= 1'b0;
      frame_valid_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      core_step_r   <= (state_s == STEP);
      frame_valid_r <= (state_s == PUBLISH);
      busy_r        <= (state_s != IDLE);
      case (state_r)
        LATCH: begin
          iter_r <= '0;
          if (bus.mouse_valid) begin
            mouse_x_r <= bus.in_mouse_x;
            mouse_y_r <= bus.in_mouse_y;
          end
        end
        STEP: begin
          done_seen_r <= '0;
          watchdog_r  <= '0;
        end
        WAIT: begin
          done_seen_r <= done_seen_r | bus.core_done;
          watchdog_r  <= watchdog_r + WW'(1);
          if (wait_done_s) begin
            if (!done_all_s) timeout_err_r <= 1'b1;
            if (!last_iter_s) iter_r <= iter_r + IW'(1);
          end
        end
        PUBLISH: begin
          nodes_x_r    <= bus.nodes_x_in;
          nodes_y_r    <= bus.nodes_y_in;
          step_count_r <= step_count_r + 16'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.core_step   = core_step_r;
  assign bus.mouse_x     = mouse_x_r;
  assign bus.mouse_y     = mouse_y_r;
  assign bus.nodes_x_out = nodes_x_r;
  assign bus.nodes_y_out = nodes_y_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.step_count  = step_count_r;
  assign bus.busy        = busy_r;
  assign bus.timeout_err = timeout_err_r;
  assign bus.overrun_err = overrun_err_r;
endmodule
